// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_CSUM = 2'd2
    } ld_state_e;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         PROG_DEPTH = 16;

    // Element [0] is the rightmost entry of the concatenation.
    localparam logic [PROG_DEPTH-1:0][7:0] DEMO_PROG = {
        8'hF0, 8'h0E, 8'hD1, 8'h2C, 8'h93, 8'h47, 8'h6A, 8'h15,
        8'h88, 8'h3B, 8'hC2, 8'h74, 8'h21, 8'h5E, 8'h09, 8'h81
    };

    function automatic int bit_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, glitch reject, framing check.
module uart_rx import loader_pkg::*; #(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
    localparam int HALF    = BIT_DIV / 2;
    localparam int CW      = $clog2(BIT_DIV + 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          rx_s1, rx_s2, rx_d;
    logic [1:0]    st;
    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            st         <= RX_IDLE;
            div_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        st      <= RX_START;
                        div_cnt <= CW'(HALF - 1);
                    end
                end
                RX_START: begin
                    if (div_cnt == '0) begin
                        // A start bit already high again at mid-bit was noise.
                        if (!rx_s2) begin
                            st      <= RX_DATA;
                            div_cnt <= CW'(BIT_DIV - 1);
                            bit_idx <= '0;
                        end else begin
                            st <= RX_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (div_cnt == '0) begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        div_cnt <= CW'(BIT_DIV - 1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            st <= RX_STOP;
                    end else begin
                        div_cnt <= div_cnt - CW'(1);
                    end
                end
                default: begin
                    if (div_cnt == '0) begin
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        st <= RX_IDLE;
                    end else begin
                        div_cnt <= div_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: sync byte, 16 data bytes, 8-bit checksum into a 16x8 store.
// Define BOOT_ROM_EN to reset the store to DEMO_PROG and start with cpu_run high.
module prog_loader import loader_pkg::*; #(
    parameter int CLK_HZ      = 27000000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 2700000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [3:0] adr,
    output logic [7:0] dout,
    output logic       cpu_run,
    output logic       loading,
    output logic       error
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef BOOT_ROM_EN
    localparam logic [PROG_DEPTH-1:0][7:0] RST_IMG = DEMO_PROG;
    localparam logic                       RST_RUN = 1'b1;
`else
    localparam logic [PROG_DEPTH-1:0][7:0] RST_IMG = '0;
    localparam logic                       RST_RUN = 1'b0;
`endif

    logic          byte_valid, frame_err;
    logic [7:0]    byte_data;
    ld_state_e     state;
    logic [3:0]    cnt;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic          tmo_hit;
    logic [7:0]    store [PROG_DEPTH];

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign tmo_hit = (tmo == TW'(TIMEOUT_CYC));
    assign loading = (state != ST_RUN);
    assign dout    = store[adr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PROG_DEPTH; i++)
                store[i] <= RST_IMG[i];
        end else if (state == ST_LOAD && byte_valid) begin
            store[cnt] <= byte_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RUN;
            cnt     <= '0;
            sum     <= '0;
            error   <= 1'b0;
            cpu_run <= RST_RUN;
            tmo     <= '0;
        end else begin
            if (byte_valid)
                tmo <= '0;
            else if (!tmo_hit)
                tmo <= tmo + TW'(1);

            case (state)
                ST_RUN: begin
                    if (byte_valid && byte_data == SYNC_BYTE) begin
                        state   <= ST_LOAD;
                        cnt     <= '0;
                        sum     <= '0;
                        error   <= 1'b0;
                        cpu_run <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Any byte here is data, including another sync byte.
                    if (byte_valid) begin
                        sum <= sum + byte_data;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'(PROG_DEPTH - 1))
                            state <= ST_CSUM;
                    end else if (frame_err || tmo_hit) begin
                        state   <= ST_RUN;
                        error   <= 1'b1;
                        cpu_run <= 1'b0;
                    end
                end
                ST_CSUM: begin
                    if (byte_valid) begin
                        state <= ST_RUN;
                        if (byte_data == sum) begin
                            cpu_run <= 1'b1;
                        end else begin
                            error   <= 1'b1;
                            cpu_run <= 1'b0;
                        end
                    end else if (frame_err || tmo_hit) begin
                        state   <= ST_RUN;
                        error   <= 1'b1;
                        cpu_run <= 1'b0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboarded UART bytes plus loader output checks.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int CLK_HZ  = 1600;
    localparam int BAUD    = 100;
    localparam int BD      = CLK_HZ / BAUD;
    localparam int TMO_CYC = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [3:0] adr = '0;
    logic [7:0] dout;
    logic       cpu_run, loading, error;

    int nchk = 0;
    int nerr = 0;
    int nbv  = 0;
    int nfe  = 0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_img [16];
    logic [7:0] rst_img [16];
    logic       rst_run;

    prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TMO_CYC)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .adr     (adr),
        .dout    (dout),
        .cpu_run (cpu_run),
        .loading (loading),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Received bytes are compared against the scoreboard in arrival order.
    always @(negedge clk) begin
        if (!reset && dut.u_rx.byte_valid) begin
            logic [8:0] want;
            want = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            chk("rx_byte", {1'b0, dut.u_rx.byte_data}, want);
            nbv++;
        end
        if (!reset && dut.u_rx.frame_err)
            nfe++;
    end

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        repeat (BD) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(posedge clk);
        end
        if (good_stop)
            exp_q.push_back(b);
        rx = good_stop;
        repeat (BD) @(posedge clk);
        rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_load(input string tag, input bit bad_csum);
        logic [7:0] s;
        s = 8'h00;
        send_byte(SYNC_BYTE, 1'b1);
        @(negedge clk);
        chk({tag, "_loading_a5"}, loading, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_byte(exp_img[i], 1'b1);
            s = s + exp_img[i];
            if (i == 8) begin
                @(negedge clk);
                chk({tag, "_loading_mid"}, loading, 1'b1);
            end
        end
        send_byte(bad_csum ? s + 8'h01 : s, 1'b1);
        @(negedge clk);
    endtask

    task automatic chk_store(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            adr = 4'(i);
            #1;
            chk(tag, {adr, dout}, {4'(i), exp_img[i]});
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
`ifdef BOOT_ROM_EN
            rst_img[i] = DEMO_PROG[i];
`else
            rst_img[i] = 8'h00;
`endif
        end
`ifdef BOOT_ROM_EN
        rst_run = 1'b1;
`else
        rst_run = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_loading", loading, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_cpu_run", cpu_run, rst_run);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_img = rst_img;
        chk_store("rst_store");

        // Good load 00..0F, checksum 78
        for (int i = 0; i < 16; i++) exp_img[i] = 8'(i);
        send_load("good", 1'b0);
        chk("good_loading", loading, 1'b0);
        chk("good_cpu_run", cpu_run, 1'b1);
        chk("good_error", error, 1'b0);
        chk_store("good_store");
        @(negedge clk); adr = 4'hA; #1;
        chk("good_dout_a", dout, 8'h0A);

        // Noise bytes in RUN are ignored
        adr = 4'h3;
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b1);
        @(negedge clk);
        chk("noise_loading", loading, 1'b0);
        chk("noise_cpu_run", cpu_run, 1'b1);
        chk("noise_dout", dout, 8'h03);

        // Sync byte inside the payload is plain data
        for (int i = 0; i < 16; i++) exp_img[i] = 8'h30 + 8'(i);
        exp_img[3] = SYNC_BYTE;
        send_load("a5data", 1'b0);
        chk("a5data_cpu_run", cpu_run, 1'b1);
        chk("a5data_error", error, 1'b0);
        chk_store("a5data_store");

        // Wrong checksum
        for (int i = 0; i < 16; i++) exp_img[i] = 8'h01;
        send_load("badcs", 1'b1);
        chk("badcs_error", error, 1'b1);
        chk("badcs_cpu_run", cpu_run, 1'b0);
        chk("badcs_loading", loading, 1'b0);
        chk_store("badcs_store");

        // Timeout after 5 data bytes; partial store kept
        send_byte(SYNC_BYTE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            exp_img[i] = 8'hC0 + 8'(i);
            send_byte(exp_img[i], 1'b1);
        end
        repeat (300) @(negedge clk);
        chk("tmo_loading_early", loading, 1'b1);
        repeat (150) @(negedge clk);
        chk("tmo_error", error, 1'b1);
        chk("tmo_loading", loading, 1'b0);
        chk("tmo_cpu_run", cpu_run, 1'b0);
        chk_store("tmo_store");

        for (int i = 0; i < 16; i++) exp_img[i] = 8'h90 - 8'(i * 3);
        send_load("recov", 1'b0);
        chk("recov_error", error, 1'b0);
        chk("recov_cpu_run", cpu_run, 1'b1);
        chk_store("recov_store");

        // Framing error mid-load
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        chk("fe_before", nfe, 0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        chk("fe_pulse", nfe, 1);
        chk("fe_error", error, 1'b1);
        chk("fe_loading", loading, 1'b0);
        chk("fe_cpu_run", cpu_run, 1'b0);

        // Short glitch on an idle line
        begin
            int bv0;
            bv0 = nbv;
            rx = 1'b0;
            repeat (5) @(posedge clk);
            rx = 1'b1;
            repeat (40) @(negedge clk);
            chk("glitch_no_byte", nbv, bv0);
            chk("glitch_no_fe", nfe, 1);
        end

        // Reset in the middle of a load
        send_byte(SYNC_BYTE, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i), 1'b1);
        @(negedge clk);
        chk("mid_loading", loading, 1'b1);
        reset = 1'b1;
        #1;
        chk("mrst_loading", loading, 1'b0);
        chk("mrst_error", error, 1'b0);
        chk("mrst_cpu_run", cpu_run, rst_run);
        @(negedge clk);
        reset = 1'b0;
        exp_img = rst_img;
        chk_store("mrst_store");

        repeat (4) @(negedge clk);
        chk("q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; BIT_DIV = CLK_HZ/BAUD, integer-truncated (234 at defaults).
REQ-003 Parameter TIMEOUT_CYC, default 2700000, maximum idle cycles allowed between bytes of one load.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rx  in  1  UART receive line, idle high, asynchronous to clk.
REQ-007 adr  in  4  instruction address from the CPU program counter.
REQ-008 dout  out  8  instruction byte at adr.
REQ-009 cpu_run  out  1  high lets the CPU execute; drives the CPU active-low reset.
REQ-010 loading  out  1  high while a load is in progress.
REQ-011 error  out  1  sticky failure flag for the last load.

Function
REQ-012 Program store: 16 x 8 flop array; dout = store[adr], combinational, valid in the same cycle as adr.
REQ-013 The UART receiver shall pass rx through a 2-flop synchronizer, detect a falling edge, and sample at mid-bit (BIT_DIV/2 after the edge, then every BIT_DIV); it shall take 8 data bits LSB first, then 1 stop bit.
REQ-014 A start bit that reads high at mid-bit shall be discarded as a glitch, and the receiver shall return to idle.
REQ-015 A stop bit that reads low is a framing error; the byte shall be dropped and a 1-cycle frame_err pulse issued.
REQ-016 Each good byte shall produce a 1-cycle byte_valid pulse with byte_data, one cycle after the stop-bit sample.
REQ-017 Loader FSM states: RUN, LOAD, CSUM.
REQ-018 RUN: a byte 0xA5 shall move the FSM to LOAD, clear cnt, sum and error, and drop cpu_run on the next clk edge; other bytes are ignored.
REQ-019 LOAD: each byte shall be written to store[cnt], added into the 8-bit sum (mod 256), and cnt incremented; after the byte at cnt=15 the FSM moves to CSUM.
REQ-020 CSUM: a byte equal to sum shall return the FSM to RUN with cpu_run=1; otherwise the FSM returns to RUN with error=1 and cpu_run=0.
REQ-021 In LOAD or CSUM, a frame_err or TIMEOUT_CYC cycles without byte_valid shall return the FSM to RUN with error=1 and cpu_run=0; a partial store is kept.
REQ-022 loading = (state != RUN).
REQ-023 cpu_run, once low, shall rise only on a matching checksum.
REQ-024 0xA5 received inside LOAD is data, not a resync.
REQ-025 Timeout counter saturates and clears on every byte_valid.
REQ-026 The checksum compare uses the sum of exactly 16 data bytes; the sync byte is excluded.

Reset
REQ-027 Reset shall set: FSM=RUN, cnt=0, sum=0, error=0, UART receiver idle, synchronizer flops=1.
REQ-028 Reset shall set the store and cpu_run as given in REQ-030/031.
REQ-029 Reset asserted mid-load shall abort the load immediately; no stored byte survives except the reset image.

Configuration
REQ-030 With BOOT_ROM_EN defined: the store resets to the package DEMO_PROG image and cpu_run resets to 1, so the demo runs from power-up.
REQ-031 Without BOOT_ROM_EN: the store resets to all 0x00 and cpu_run resets to 0; the CPU is held until the first good load.

Structure
REQ-032 Package loader_pkg shall hold: the state enum, SYNC_BYTE=8'hA5, PROG_DEPTH=16, and DEMO_PROG (16 x 8 constant).
REQ-033 Sub-module uart_rx (params CLK_HZ, BAUD; ports clk, reset, rx, byte_valid, byte_data, frame_err) shall contain REQ-013..016; prog_loader instantiates it once.

Verification
REQ-034 Send A5, 00..0F, 78 -> loading high from the A5 stop bit until the checksum byte; then store[i]=i, cpu_run=1, error=0; adr=4'hA gives dout=8'h0A.
REQ-035 Send A5, 16 x 01, 11 (wrong, expected 10) -> error=1, cpu_run=0, loading=0; store holds 01s.
REQ-036 Send A5 plus 5 bytes, then idle > TIMEOUT_CYC -> error=1, state RUN, cpu_run=0; a following valid load clears error and sets cpu_run=1.
REQ-037 Send a byte with stop bit forced low during LOAD -> frame_err pulse, error=1, loading=0; a 0.3-bit low glitch on idle rx -> no byte_valid.
REQ-038 Assert reset at cnt=8 -> state RUN, error=0; with BOOT_ROM_EN: store=DEMO_PROG and cpu_run=1; without: store=0 and cpu_run=0.
REQ-039 In RUN, send 3C, 5A -> no state change, cpu_run unchanged, dout unchanged.
